// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit boundary: instruction-memory request/response channel, decoder-facing
// instruction hold register, and the execute-stage redirect input.
interface instruction_fetch_unit_if;
  // A request transfers on a rising edge where memory_request_valid and
  // memory_request_ready are both high. While valid is high and ready is low, the
  // request stays asserted, although a redirect may change its address. Responses
  // carry no ready: they are sampled whenever memory_response_valid is high.
  logic        memory_request_valid;
  logic        memory_request_ready;
  logic [31:0] memory_request_address;
  logic        memory_response_valid;
  logic [31:0] memory_response_data;
  logic [31:0] instruction_register;
  logic        instruction_valid;
  logic        instruction_accept;
  logic [31:0] program_counter;
  logic        redirect_enable;
  logic [31:0] redirect_address;

  modport master (
    output memory_request_valid,
    output memory_request_address,
    input  memory_request_ready,
    input  memory_response_valid,
    input  memory_response_data,
    output instruction_register,
    output instruction_valid,
    output program_counter,
    input  instruction_accept,
    input  redirect_enable,
    input  redirect_address
  );

  modport slave (
    input  memory_request_valid,
    input  memory_request_address,
    output memory_request_ready,
    output memory_response_valid,
    output memory_response_data,
    input  instruction_register,
    input  instruction_valid,
    input  program_counter,
    output instruction_accept,
    output redirect_enable,
    output redirect_address
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding instruction fetch: REQUEST -> WAIT -> HOLD, with redirect
// handling that drops any fetch still in flight when the PC is replaced.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0013
) (
  input  logic                       clock,
  input  logic                       reset_n,
  instruction_fetch_unit_if.master   bus,
  output logic [1:0]                 debug_state_o
);

  localparam logic [1:0] S_REQUEST = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        discard_q, discard_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_q, pc_d;
  logic        ivalid_q, ivalid_d;

  logic        req_valid;
  logic        handshake;
  logic [31:0] redirect_target;

  assign req_valid       = reset_n && (state_q == S_REQUEST);
  assign handshake       = req_valid && bus.memory_request_ready;
  assign redirect_target = {bus.redirect_address[31:2], 2'b00};

  assign bus.memory_request_valid   = req_valid;
  assign bus.memory_request_address = fetch_pc_q;
  assign bus.instruction_register   = ir_q;
  assign bus.instruction_valid      = ivalid_q;
  assign bus.program_counter        = pc_q;
  assign debug_state_o              = state_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    ivalid_d   = ivalid_q;

    case (state_q)
      S_REQUEST: begin
        if (bus.redirect_enable) begin
          fetch_pc_d = redirect_target;
          // The old-address request already went out; its response must be dropped.
          if (handshake) begin
            state_d   = S_WAIT;
            discard_d = 1'b1;
          end
        end else if (handshake) begin
          state_d   = S_WAIT;
          discard_d = 1'b0;
        end
      end

      S_WAIT: begin
        if (bus.redirect_enable) begin
          fetch_pc_d = redirect_target;
          if (bus.memory_response_valid) begin
            state_d   = S_REQUEST;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end else if (bus.memory_response_valid) begin
          if (discard_q) begin
            state_d   = S_REQUEST;
            discard_d = 1'b0;
          end else begin
            ir_d       = bus.memory_response_data;
            pc_d       = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
            ivalid_d   = 1'b1;
            state_d    = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        // Redirect outranks a same-cycle accept; the held word is simply invalidated.
        if (bus.redirect_enable) begin
          fetch_pc_d = redirect_target;
          ivalid_d   = 1'b0;
          state_d    = S_REQUEST;
        end else if (bus.instruction_accept) begin
          ivalid_d = 1'b0;
          state_d  = S_REQUEST;
        end
      end

      default: begin
        state_d = S_REQUEST;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= S_REQUEST;
      fetch_pc_q <= RESET_VECTOR;
      discard_q  <= 1'b0;
      ir_q       <= NOP_INSTRUCTION;
      pc_q       <= RESET_VECTOR;
      ivalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      ivalid_q   <= ivalid_d;
    end
  end

endmodule
